sobel_frame_ctrl: RTL and testbench
===================================

// Module: sobel_frame_ctrl
// PURPOSE
//   Frame-level sequencer wrapped around the sobel pixel core. Arms on a start
//   pulse and admits exactly IMG_W*IMG_H input pixels into the core, then drains
//   the core. Tracks output raster position, zeroes border pixels and emits
//   frame/line markers. Sits between the pixel source and the downstream sink.
// PARAMETERS
//   IMG_W       640   pixels per line (>=2)
//   IMG_H       480   lines per frame (>=2)
//   DRAIN_TMO   64    max idle cycles in DRAIN with no core output before abort
// PORTS
//   clk             in   1  system clock; all logic on rising edge
//   rst             in   1  synchronous, active-high reset
//   start           in   1  arm a frame; honoured only in IDLE
//   valid_in        in   1  source pixel strobe (no backpressure)
//   pixel_in        in   8  source pixel
//   core_valid_in   out  1  strobe to sobel core
//   core_pixel_in   out  8  pixel to sobel core
//   core_valid_out  in   1  strobe from sobel core
//   core_pixel_out  in   8  pixel from sobel core
//   valid_out       out  1  output pixel strobe
//   pixel_out       out  8  output pixel, border-masked
//   sof_out         out  1  with valid_out on first pixel of frame
//   eol_out         out  1  with valid_out on col IMG_W-1
//   eof_out         out  1  with valid_out on last pixel of frame
//   busy            out  1  state != IDLE
//   done            out  1  one-cycle pulse at frame end
//   drop_err        out  1  sticky: valid_in seen outside RUN
//   tmo_err         out  1  sticky: drain timeout occurred
// BEHAVIOUR
//   Reset: state=IDLE; all counters 0; every output 0 (incl. sticky errors).
//   FSM: IDLE -start-> RUN (clears counters, drop_err, tmo_err).
//     RUN: on last input pixel accepted (col=IMG_W-1,row=IMG_H-1) -> DRAIN.
//     DRAIN: last output pixel seen -> DONE; DRAIN_TMO consecutive cycles w/o
//       core_valid_out -> set tmo_err, -> DONE. Timer resets on core_valid_out.
//     DONE: done=1 for exactly this cycle -> IDLE.
//   Input path (combinational): core_valid_in = valid_in & (state==RUN);
//     core_pixel_in = pixel_in. valid_in outside RUN: dropped, drop_err<=1.
//   Output path: registered, 1-cycle latency core_valid_out -> valid_out.
//     Accepted only in RUN or DRAIN; ignored in IDLE/DONE.
//     pixel_out = 0 if out row in {0,IMG_H-1} or out col in {0,IMG_W-1},
//     else core_pixel_out. pixel_out holds last value when valid_out=0.
//   Counters: col wraps IMG_W-1 -> 0 and increments row; row saturates at
//     frame end; widths $clog2(IMG_W), $clog2(IMG_H). Out counter may run
//     ahead of input during RUN (core latency is arbitrary >=0).
//   Simultaneous: start while busy ignored. Last input pixel and core output
//     on same cycle both processed. Last output in RUN (zero-latency core)
//     still completes via DRAIN on next cycle -> DONE.
//   Reset mid-frame: abandons frame immediately; no done, no eof.
// STRUCTURE
//   sobel_pkg: state encoding (IDLE/RUN/DRAIN/DONE), PIX_W=8, BORDER_VAL=0.
//   Sub-module sobel_pos_counter (col/row raster counter with last flags),
//   instantiated twice: input side and output side.
// TESTING (IMG_W=4, IMG_H=3, core = 1-cycle passthrough)
//   1 start, 12 back-to-back valid_in (pixel=idx+10) -> valid_out x12, pixel_out
//     nonzero only for idx 5,6 (15,16); sof on idx0, eol on 3,7,11; eof on 11;
//     done 1 cycle after eof; busy low next cycle.
//   2 valid_in with gaps (every 3rd cycle) -> same output values/markers, done once.
//   3 valid_in in IDLE before start -> core_valid_in=0, drop_err=1; next start
//     clears it.
//   4 core stalled (no core_valid_out) after input -> tmo_err=1 after 64 cycles,
//     done pulse, state IDLE.
//   5 rst at pixel 6 -> all outputs 0 next cycle; new start runs clean frame.
//   6 start pulse during RUN -> ignored; frame counts and done unaffected.

Source files
------------

// File: rtl/sobel_frame_ctrl_pkg.sv
// sobel_pkg: shared definitions for the sobel frame controller.
//   PIX_W      - pixel width
//   BORDER_VAL - value written to pixels on the frame border
//   state_e    - frame sequencer state encoding
package sobel_pkg;

    localparam int PIX_W = 8;
    localparam logic [PIX_W-1:0] BORDER_VAL = '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/sobel_frame_ctrl_if.sv
// sobel_frame_ctrl_if: all non-clock/reset signals of the frame controller.
//   master : controller view (drives core inputs, sink stream, status)
//   slave  : environment view (source, sobel core, sink, control)
//   Source : start, valid_in, pixel_in
//   Core   : core_valid_in/core_pixel_in (to core), core_valid_out/core_pixel_out (from core)
//   Sink   : valid_out, pixel_out, sof_out, eol_out, eof_out
//   Status : busy, done, drop_err, tmo_err
interface sobel_frame_ctrl_if;
    import sobel_pkg::*;

    logic             start;
    logic             valid_in;
    logic [PIX_W-1:0] pixel_in;
    logic             core_valid_in;
    logic [PIX_W-1:0] core_pixel_in;
    logic             core_valid_out;
    logic [PIX_W-1:0] core_pixel_out;
    logic             valid_out;
    logic [PIX_W-1:0] pixel_out;
    logic             sof_out;
    logic             eol_out;
    logic             eof_out;
    logic             busy;
    logic             done;
    logic             drop_err;
    logic             tmo_err;

    modport master (
        input  start, valid_in, pixel_in, core_valid_out, core_pixel_out,
        output core_valid_in, core_pixel_in, valid_out, pixel_out,
               sof_out, eol_out, eof_out, busy, done, drop_err, tmo_err
    );

    modport slave (
        output start, valid_in, pixel_in, core_valid_out, core_pixel_out,
        input  core_valid_in, core_pixel_in, valid_out, pixel_out,
               sof_out, eol_out, eof_out, busy, done, drop_err, tmo_err
    );

endinterface

// File: rtl/sobel_frame_ctrl_pos_counter.sv
// sobel_pos_counter: raster position counter (col, row) for one frame.
//   clk, rst     : clock, synchronous active-high reset
//   clr_i        : return to (0,0)
//   adv_i        : advance one pixel; holds once the last pixel is reached
//   col_o, row_o : current position
//   col_last_o   : col == IMG_W-1
//   last_o       : position is the final pixel of the frame
module sobel_pos_counter #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr_i,
    input  logic                     adv_i,
    output logic [$clog2(IMG_W)-1:0] col_o,
    output logic [$clog2(IMG_H)-1:0] row_o,
    output logic                     col_last_o,
    output logic                     last_o
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;

    assign col_last_o = (col_q == COL_MAX);
    assign last_o     = col_last_o && (row_q == ROW_MAX);
    assign col_o      = col_q;
    assign row_o      = row_q;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clr_i) begin
            col_d = '0;
            row_d = '0;
        end else if (adv_i && !last_o) begin
            // saturate on the final pixel so a stray advance cannot wrap the frame
            if (col_last_o) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/sobel_frame_ctrl.sv
// sobel_frame_ctrl: frame sequencer around the sobel pixel core.
//   clk, rst : clock, synchronous active-high reset
//   bus      : sobel_frame_ctrl_if.master (source, core, sink, status)
// Admits exactly IMG_W*IMG_H pixels into the core after a start in IDLE,
// drains the core, masks border pixels to BORDER_VAL and emits sof/eol/eof
// with a one-cycle registered output path.
module sobel_frame_ctrl
    import sobel_pkg::*;
#(
    parameter int IMG_W     = 640,
    parameter int IMG_H     = 480,
    parameter int DRAIN_TMO = 64
) (
    input  logic                clk,
    input  logic                rst,
    sobel_frame_ctrl_if.master  bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int TW = $clog2(DRAIN_TMO + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(DRAIN_TMO - 1);
    localparam logic [RW-1:0] ROW_MAX  = RW'(IMG_H - 1);

    state_e state_q, state_d;

    logic             start_acc, in_acc, out_acc, tmo_hit;
    logic             in_last;
    logic [CW-1:0]    in_unused_col;
    logic [RW-1:0]    in_unused_row;
    logic             in_unused_col_last;
    logic [CW-1:0]    out_col;
    logic [RW-1:0]    out_row;
    logic             out_col_last, out_last, out_border;

    logic [TW-1:0]    tmr_q, tmr_d;
    logic             out_done_q, out_done_d;
    logic             drop_q, drop_d;
    logic             tmo_q, tmo_d;
    logic             vld_q, sof_q, eol_q, eof_q;
    logic [PIX_W-1:0] pix_q, pix_d;

    assign start_acc = bus.start && (state_q == ST_IDLE);
    assign in_acc    = bus.valid_in && (state_q == ST_RUN);
    // once the final output is counted, later core strobes belong to no frame
    assign out_acc   = bus.core_valid_out && !out_done_q &&
                       ((state_q == ST_RUN) || (state_q == ST_DRAIN));

    sobel_pos_counter #(.IMG_W(IMG_W), .IMG_H(IMG_H)) u_in_pos (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (start_acc),
        .adv_i      (in_acc),
        .col_o      (in_unused_col),
        .row_o      (in_unused_row),
        .col_last_o (in_unused_col_last),
        .last_o     (in_last)
    );

    sobel_pos_counter #(.IMG_W(IMG_W), .IMG_H(IMG_H)) u_out_pos (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (start_acc),
        .adv_i      (out_acc),
        .col_o      (out_col),
        .row_o      (out_row),
        .col_last_o (out_col_last),
        .last_o     (out_last)
    );

    assign out_border = (out_row == '0) || (out_row == ROW_MAX) ||
                        (out_col == '0) || out_col_last;

    always_comb begin
        state_d = state_q;
        tmo_hit = 1'b0;
        case (state_q)
            ST_IDLE:  if (bus.start) state_d = ST_RUN;
            ST_RUN:   if (in_acc && in_last) state_d = ST_DRAIN;
            ST_DRAIN: begin
                // out_done_q is registered, so done lands one cycle after eof
                if (out_done_q) begin
                    state_d = ST_DONE;
                end else if (!bus.core_valid_out && (tmr_q == TMO_LAST)) begin
                    tmo_hit = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tmr_d      = ((state_q == ST_DRAIN) && !bus.core_valid_out) ? tmr_q + 1'b1 : '0;
        out_done_d = start_acc ? 1'b0 : (out_done_q || (out_acc && out_last));
        tmo_d      = start_acc ? 1'b0 : (tmo_q || tmo_hit);
        // a pixel dropped on the arming cycle still counts as dropped
        drop_d     = start_acc ? 1'b0 : drop_q;
        if (bus.valid_in && (state_q != ST_RUN)) drop_d = 1'b1;
        pix_d      = pix_q;
        if (out_acc) pix_d = out_border ? BORDER_VAL : bus.core_pixel_out;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tmr_q      <= '0;
            out_done_q <= 1'b0;
            drop_q     <= 1'b0;
            tmo_q      <= 1'b0;
            vld_q      <= 1'b0;
            sof_q      <= 1'b0;
            eol_q      <= 1'b0;
            eof_q      <= 1'b0;
            pix_q      <= '0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            out_done_q <= out_done_d;
            drop_q     <= drop_d;
            tmo_q      <= tmo_d;
            vld_q      <= out_acc;
            sof_q      <= out_acc && (out_col == '0) && (out_row == '0);
            eol_q      <= out_acc && out_col_last;
            eof_q      <= out_acc && out_last;
            pix_q      <= pix_d;
        end
    end

    assign bus.core_valid_in = in_acc;
    assign bus.core_pixel_in = bus.pixel_in;
    assign bus.valid_out     = vld_q;
    assign bus.pixel_out     = pix_q;
    assign bus.sof_out       = sof_q;
    assign bus.eol_out       = eol_q;
    assign bus.eof_out       = eof_q;
    assign bus.busy          = (state_q != ST_IDLE);
    assign bus.done          = (state_q == ST_DONE);
    assign bus.drop_err      = drop_q;
    assign bus.tmo_err       = tmo_q;

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Testbench for sobel_frame_ctrl with IMG_W=4, IMG_H=3 and a 1-cycle
// passthrough core model.
module tb_sobel_frame_ctrl;

    typedef struct {
        logic [7:0] in;
        logic [7:0] pix;
        logic       sof;
        logic       eol;
        logic       eof;
    } vec_t;

    typedef struct {
        logic [7:0] pix;
        logic       sof;
        logic       eol;
        logic       eof;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic core_en = 1'b1;
    logic hold_en = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   eof_cyc = -100;
    vec_t tbl[12];
    obs_t obs[$];

    sobel_frame_ctrl_if bus ();

    sobel_frame_ctrl #(.IMG_W(4), .IMG_H(3), .DRAIN_TMO(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // 1-cycle passthrough sobel core; core_en=0 models a stalled core
    always @(posedge clk) begin
        bus.core_valid_out <= bus.core_valid_in & core_en;
        bus.core_pixel_out <= bus.core_pixel_in;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (bus.valid_out) begin
            obs_t o;
            o.pix = bus.pixel_out;
            o.sof = bus.sof_out;
            o.eol = bus.eol_out;
            o.eof = bus.eof_out;
            obs.push_back(o);
            if (bus.eof_out) eof_cyc = cyc;
        end
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (hold_en && !bus.valid_out && obs.size() > 0)
            chk("pixel_hold", bus.pixel_out, obs[obs.size()-1].pix);
    end

    task automatic start_frame();
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
    endtask

    task automatic feed(input int gap, input int start_at);
        for (int i = 0; i < 12; i++) begin
            bus.valid_in = 1'b1;
            bus.pixel_in = tbl[i].in;
            bus.start    = (i == start_at);
            @(posedge clk); #1;
            bus.valid_in = 1'b0;
            bus.start    = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    task automatic wait_done(input string name, input int bound);
        int n = 0;
        while (done_cnt == 0 && n < bound) begin
            @(negedge clk); #1;
            n++;
        end
        chk({name, "_done_seen"}, done_cnt > 0, 1);
    endtask

    task automatic finish_frame(input string name, input int gap, input int start_at);
        feed(gap, start_at);
        wait_done(name, 300);
        chk({name, "_count"}, obs.size(), 12);
        for (int i = 0; i < 12; i++) begin
            if (i < obs.size()) begin
                chk($sformatf("%s_pix%0d", name, i), obs[i].pix, tbl[i].pix);
                chk($sformatf("%s_sof%0d", name, i), obs[i].sof, tbl[i].sof);
                chk($sformatf("%s_eol%0d", name, i), obs[i].eol, tbl[i].eol);
                chk($sformatf("%s_eof%0d", name, i), obs[i].eof, tbl[i].eof);
            end
        end
        chk({name, "_done_after_eof"}, done_cyc, eof_cyc + 1);
        chk({name, "_drop_err"}, bus.drop_err, 0);
        chk({name, "_tmo_err"}, bus.tmo_err, 0);
        @(negedge clk); #1;
        chk({name, "_busy_low"}, bus.busy, 0);
        repeat (3) @(negedge clk);
        chk({name, "_done_once"}, done_cnt, 1);
    endtask

    task automatic run_frame(input string name, input int gap, input int start_at);
        obs.delete();
        done_cnt = 0;
        start_frame();
        finish_frame(name, gap, start_at);
    endtask

    initial begin
        logic [7:0] ep [12] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd15,
                                8'd16, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        for (int i = 0; i < 12; i++) begin
            tbl[i].in  = 8'(i + 10);
            tbl[i].pix = ep[i];
            tbl[i].sof = (i == 0);
            tbl[i].eol = (i == 3) || (i == 7) || (i == 11);
            tbl[i].eof = (i == 11);
        end

        bus.start = 1'b0;
        bus.valid_in = 1'b0;
        bus.pixel_in = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_valid_out", bus.valid_out, 0);
        chk("rst_pixel_out", bus.pixel_out, 0);
        chk("rst_markers", {bus.sof_out, bus.eol_out, bus.eof_out}, 0);
        chk("rst_busy_done", {bus.busy, bus.done}, 0);
        chk("rst_errs", {bus.drop_err, bus.tmo_err}, 0);

        // 1: back-to-back frame
        run_frame("t1", 0, -1);

        // 2: every 3rd cycle, pixel_out must hold between strobes
        hold_en = 1'b1;
        run_frame("t2", 2, -1);
        hold_en = 1'b0;

        // 3: valid_in in IDLE is dropped and flagged; start clears the flag
        @(posedge clk); #1;
        bus.valid_in = 1'b1;
        bus.pixel_in = 8'd99;
        @(negedge clk);
        chk("t3_core_valid_in", bus.core_valid_in, 0);
        @(posedge clk); #1 bus.valid_in = 1'b0;
        @(negedge clk);
        chk("t3_drop_err_set", bus.drop_err, 1);
        obs.delete();
        done_cnt = 0;
        start_frame();
        @(negedge clk);
        chk("t3_drop_err_clr", bus.drop_err, 0);
        chk("t3_busy", bus.busy, 1);
        finish_frame("t3", 0, -1);

        // 4: stalled core -> timeout on the 64th idle drain cycle
        obs.delete();
        done_cnt = 0;
        core_en = 1'b0;
        start_frame();
        feed(0, -1);
        repeat (63) @(posedge clk);
        @(negedge clk);
        chk("t4_tmo_early", bus.tmo_err, 0);
        chk("t4_done_early", bus.done, 0);
        chk("t4_busy_drain", bus.busy, 1);
        @(posedge clk);
        @(negedge clk);
        chk("t4_done", bus.done, 1);
        chk("t4_tmo_err", bus.tmo_err, 1);
        @(negedge clk);
        chk("t4_idle", bus.busy, 0);
        chk("t4_tmo_sticky", bus.tmo_err, 1);
        chk("t4_no_output", obs.size(), 0);
        core_en = 1'b1;

        // 5: reset on pixel 6 abandons the frame
        obs.delete();
        done_cnt = 0;
        eof_cyc = -100;
        start_frame();
        for (int i = 0; i < 6; i++) begin
            bus.valid_in = 1'b1;
            bus.pixel_in = tbl[i].in;
            @(posedge clk); #1;
        end
        bus.pixel_in = tbl[6].in;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.valid_in = 1'b0;
        @(negedge clk);
        chk("t5_valid_out", bus.valid_out, 0);
        chk("t5_pixel_out", bus.pixel_out, 0);
        chk("t5_markers", {bus.sof_out, bus.eol_out, bus.eof_out}, 0);
        chk("t5_busy_done", {bus.busy, bus.done}, 0);
        chk("t5_errs", {bus.drop_err, bus.tmo_err}, 0);
        repeat (5) @(negedge clk);
        chk("t5_no_done", done_cnt, 0);
        chk("t5_no_eof", eof_cyc, -100);
        run_frame("t5b", 0, -1);

        // 6: start during RUN is ignored
        run_frame("t6", 0, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
